reg_status_file: RTL
====================

// Module: reg_status_file
// PURPOSE
// Architectural register file with per-register rename status (Tomasulo RAT).
// Commit side consumes the ROB write-back triple (reg, rob tag, value).
// The decoder side renames a destination to a ROB tag and reads source operands as a value or a pending tag.
// Misbranch flushes all speculative renames; the committed values are kept.
// PARAMETERS
// REG_NUM    32  number of architectural registers; x0 hardwired to zero
// REG_W      5   register index width
// DATA_W     32  data width
// ROB_W      4   ROB tag width; tag 0 = "no producer"; tags 1..2^ROB_W-1 are valid
// PORTS
// clk              in   1       clock, rising edge
// rst              in   1       asynchronous reset, active-low
// ena              in   1       global enable; low = hold all state
// in_commit_reg    in   REG_W   committed dest reg (0 = no commit)
// in_commit_rob    in   ROB_W   ROB tag of the committing entry
// in_commit_value  in   DATA_W  committed value
// in_rename_ena    in   1       decoder assigns new producer this cycle
// in_rename_reg    in   REG_W   renamed dest reg
// in_rename_rob    in   ROB_W   ROB tag now producing in_rename_reg
// in_misbranch     in   1       flush all rename tags
// in_query_reg1/2  in   REG_W   source operand indices
// out_busy1/2      out  1       operand pending in ROB
// out_tag1/2       out  ROB_W   producer tag if busy, else 0
// out_value1/2     out  DATA_W  register value if not busy, else 0
// BEHAVIOUR
// - Reset (rst=0, async): all values and tags = 0. Queries then return busy=0, tag=0, value=0.
// - State: value[REG_NUM], tag[REG_NUM]. busy == (tag != 0). Register 0 is never written, never renamed, and always reads 0/not busy.
// - All updates occur on posedge clk when rst=1 and ena=1. ena=0 holds state; query outputs remain live.
// - Commit (in_commit_reg!=0):
//   - value[reg] <= in_commit_value unconditionally; commits arrive in program order.
//   - tag[reg] <= 0 only if tag[reg]==in_commit_rob; a younger rename keeps the register busy.
// - Rename (in_rename_ena && in_rename_reg!=0 && !in_misbranch): tag[reg] <= in_rename_rob.
// - Same-cycle commit and rename on the same reg: the value is written and rename wins the tag.
// - Misbranch: all tags <= 0 in that cycle; a same-cycle commit still writes its value; a same-cycle rename is dropped.
// - Queries are combinational, zero latency, with commit bypass:
//   - If query==in_commit_reg!=0, tag[q]==in_commit_rob, and ena=1: busy=0, tag=0, value=in_commit_value.
//   - Else if tag[q]!=0: busy=1, tag=tag[q], value=0.
//   - Else: busy=0, tag=0, value=value[q].
// - Query reads are not bypassed from a same-cycle rename. The decoder resolves intra-instruction dependencies itself.
// - Reset deasserting mid-operation: the first edge after deassert sees the cleared state; no partial commit survives.
// TESTING
// 1 Reset: rst=0 then 1; query x5 -> busy=0, tag=0, value=0.
// 2 Rename x5->tag3; next cycle query x5 -> busy=1, tag=3.
//   Commit (x5, 3, 0xDEADBEEF) -> tag cleared; query gives 0xDEADBEEF.
//   During the commit cycle itself the bypass already gives busy=0, value 0xDEADBEEF.
// 3 Stale commit: rename x7->2, then rename x7->6; commit (x7, 2, 0x11) ->
//   value=0x11 stored but query still busy=1, tag=6.
//   Commit (x7, 6, 0x22) -> busy=0, value 0x22.
// 4 Same cycle: commit (x9, 4, 0x55) plus rename x9->8 -> next cycle busy=1, tag=8, and the internal value is 0x55.
// 5 Misbranch: rename x1->1, x2->2, x3->3; pulse in_misbranch with rename x4->5 and commit (x1, 1, 0x7) ->
//   all busy=0; x1=0x7; x4 not renamed.
// 6 x0 and ena: rename x0->3 and commit (x0, 3, 0xFF) -> x0 reads 0, not busy.
//   With ena=0, rename x5->2 -> x5 is unchanged.

Source files
------------

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (Tomasulo RAT).
// Commit writes values and retires matching tags; rename and misbranch manage producer tags.
module reg_status_file #(
  parameter int REG_NUM = 32,
  parameter int REG_W   = 5,
  parameter int DATA_W  = 32,
  parameter int ROB_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [REG_W-1:0]  in_commit_reg,
  input  logic [ROB_W-1:0]  in_commit_rob,
  input  logic [DATA_W-1:0] in_commit_value,
  input  logic              in_rename_ena,
  input  logic [REG_W-1:0]  in_rename_reg,
  input  logic [ROB_W-1:0]  in_rename_rob,
  input  logic              in_misbranch,
  input  logic [REG_W-1:0]  in_query_reg1,
  input  logic [REG_W-1:0]  in_query_reg2,
  output logic              out_busy1,
  output logic [ROB_W-1:0]  out_tag1,
  output logic [DATA_W-1:0] out_value1,
  output logic              out_busy2,
  output logic [ROB_W-1:0]  out_tag2,
  output logic [DATA_W-1:0] out_value2
);

  localparam int Q_W = 1 + ROB_W + DATA_W;

  logic [DATA_W-1:0] value_r [REG_NUM];
  logic [ROB_W-1:0]  tag_r   [REG_NUM];
  logic [Q_W-1:0]    query1_s;
  logic [Q_W-1:0]    query2_s;

  // Resolves one source operand: commit bypass, then pending tag, then stored value.
  function automatic logic [Q_W-1:0] query_f(
    input logic [REG_W-1:0]  q,
    input logic [ROB_W-1:0]  tag,
    input logic [DATA_W-1:0] value
  );
    logic [Q_W-1:0] res;
    if (ena && (q != {REG_W{1'b0}}) && (q == in_commit_reg) && (tag == in_commit_rob)) begin
      res = {1'b0, {ROB_W{1'b0}}, in_commit_value};
    end else if (tag != {ROB_W{1'b0}}) begin
      res = {1'b1, tag, {DATA_W{1'b0}}};
    end else begin
      res = {1'b0, {ROB_W{1'b0}}, value};
    end
    return res;
  endfunction

  // Register state update; entry 0 is never written so x0 stays zero and idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        value_r[i] <= {DATA_W{1'b0}};
        tag_r[i]   <= {ROB_W{1'b0}};
      end
    end else if (ena) begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (in_commit_reg == REG_W'(i)) begin
          value_r[i] <= in_commit_value;
        end
        // Misbranch beats rename; rename beats a same-register commit for the tag.
        if (in_misbranch) begin
          tag_r[i] <= {ROB_W{1'b0}};
        end else if (in_rename_ena && (in_rename_reg == REG_W'(i))) begin
          tag_r[i] <= in_rename_rob;
        end else if ((in_commit_reg == REG_W'(i)) && (tag_r[i] == in_commit_rob)) begin
          tag_r[i] <= {ROB_W{1'b0}};
        end
      end
    end
  end

  // Combinational operand lookup for both query ports.
  always_comb begin
    query1_s = query_f(in_query_reg1, tag_r[in_query_reg1], value_r[in_query_reg1]);
    query2_s = query_f(in_query_reg2, tag_r[in_query_reg2], value_r[in_query_reg2]);
  end

  assign {out_busy1, out_tag1, out_value1} = query1_s;
  assign {out_busy2, out_tag2, out_value2} = query2_s;

endmodule
